// File: rtl/fft_output_reorder.sv
// Ping-pong bit-reversal reorder buffer: frames arrive in bit-reversed bin order and
// leave in natural order, one bin per cycle, 1 cycle after the last sample; no backpressure.
module fft_output_reorder #(
  parameter int N_LOG2 = 8,
  parameter int WIDTH  = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_real,
  input  logic [WIDTH-1:0] in_imag,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_real,
  output logic [WIDTH-1:0] out_imag,
  output logic             out_first,
  output logic             out_last
);

  localparam int N = 1 << N_LOG2;
  localparam logic [N_LOG2-1:0] CNT_MAX = {N_LOG2{1'b1}};

  typedef enum logic {IDLE, DRAIN} state_t;

  // Bank select is the address MSB: {bank, index}.
  logic [2*WIDTH-1:0] mem_q [2*N];

  logic [N_LOG2-1:0] wr_cnt_q, wr_cnt_d;
  logic              wr_bank_q, wr_bank_d;
  logic              frame_done;

  state_t            state_q, state_d;
  logic [N_LOG2-1:0] rd_cnt_q, rd_cnt_d;
  logic              rd_bank_q, rd_bank_d;
  logic              issue;
  logic [2*WIDTH-1:0] rd_word;

  logic             out_valid_q, out_valid_d;
  logic             out_first_q, out_first_d;
  logic             out_last_q, out_last_d;
  logic [WIDTH-1:0] out_real_q, out_real_d;
  logic [WIDTH-1:0] out_imag_q, out_imag_d;

  function automatic logic [N_LOG2-1:0] bitrev(input logic [N_LOG2-1:0] x);
    logic [N_LOG2-1:0] r;
    for (int b = 0; b < N_LOG2; b++) begin
      r[b] = x[N_LOG2-1-b];
    end
    return r;
  endfunction

  always_comb begin
    frame_done = in_valid && (wr_cnt_q == CNT_MAX);
    wr_cnt_d   = in_valid ? wr_cnt_q + N_LOG2'(1) : wr_cnt_q;
    wr_bank_d  = wr_bank_q ^ frame_done;
  end

  // Memory is deliberately not reset; a bank is only read after a complete fill.
  always_ff @(posedge clock) begin
    if (in_valid && !reset) begin
      mem_q[{wr_bank_q, wr_cnt_q}] <= {in_real, in_imag};
    end
  end

  always_comb begin
    state_d   = state_q;
    rd_cnt_d  = rd_cnt_q;
    rd_bank_d = rd_bank_q;
    issue     = (state_q == DRAIN);
    rd_word   = mem_q[{rd_bank_q, bitrev(rd_cnt_q)}];

    if (state_q == IDLE) begin
      if (frame_done) begin
        state_d   = DRAIN;
        rd_bank_d = wr_bank_q;
        rd_cnt_d  = '0;
      end
    end else begin
      rd_cnt_d = rd_cnt_q + N_LOG2'(1);
      if (rd_cnt_q == CNT_MAX) begin
        // A frame completing on the final bin chains straight into the next drain.
        if (frame_done) begin
          rd_bank_d = wr_bank_q;
          rd_cnt_d  = '0;
        end else begin
          state_d = IDLE;
        end
      end
    end

    out_valid_d = issue;
    out_first_d = issue && (rd_cnt_q == '0);
    out_last_d  = issue && (rd_cnt_q == CNT_MAX);
    out_real_d  = issue ? rd_word[2*WIDTH-1:WIDTH] : out_real_q;
    out_imag_d  = issue ? rd_word[WIDTH-1:0]       : out_imag_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_cnt_q    <= '0;
      wr_bank_q   <= 1'b0;
      state_q     <= IDLE;
      rd_cnt_q    <= '0;
      rd_bank_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_real_q  <= '0;
      out_imag_q  <= '0;
    end else begin
      wr_cnt_q    <= wr_cnt_d;
      wr_bank_q   <= wr_bank_d;
      state_q     <= state_d;
      rd_cnt_q    <= rd_cnt_d;
      rd_bank_q   <= rd_bank_d;
      out_valid_q <= out_valid_d;
      out_first_q <= out_first_d;
      out_last_q  <= out_last_d;
      out_real_q  <= out_real_d;
      out_imag_q  <= out_imag_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_first = out_first_q;
  assign out_last  = out_last_q;
  assign out_real  = out_real_q;
  assign out_imag  = out_imag_q;

endmodule

// File: tb/tb_fft_output_reorder.sv
// Directed bench: 256-point instance checked cycle-exactly by a scoreboard,
// 8-point instance checked against literal bin tables.
module tb_fft_output_reorder;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_real = '0, in_imag = '0;
  logic        out_valid, out_first, out_last;
  logic [31:0] out_real, out_imag;

  logic        in_valid3 = 1'b0;
  logic [15:0] in_real3 = '0, in_imag3 = '0;
  logic        out_valid3, out_first3, out_last3;
  logic [15:0] out_real3, out_imag3;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] r;
    logic [31:0] i;
    logic        f;
    logic        l;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  fft_output_reorder #(.N_LOG2(8), .WIDTH(32)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_real(in_real), .in_imag(in_imag),
    .out_valid(out_valid), .out_real(out_real), .out_imag(out_imag),
    .out_first(out_first), .out_last(out_last)
  );

  fft_output_reorder #(.N_LOG2(3), .WIDTH(16)) dut3 (
    .clock(clock), .reset(reset), .in_valid(in_valid3), .in_real(in_real3), .in_imag(in_imag3),
    .out_valid(out_valid3), .out_real(out_real3), .out_imag(out_imag3),
    .out_first(out_first3), .out_last(out_last3)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int bitrev8(input int x);
    int r = 0;
    for (int b = 0; b < 8; b++) if (x[b]) r |= (1 << (7 - b));
    return r;
  endfunction

  // Last sample captured at edge t: bin j is due after edge t+1+j.
  task automatic push_frame(input int off, input int t);
    exp_t e;
    for (int j = 0; j < 256; j++) begin
      e.r   = 32'(off + bitrev8(j));
      e.i   = 32'(255 - bitrev8(j));
      e.f   = (j == 0);
      e.l   = (j == 255);
      e.cyc = t + 1 + j;
      sb.push_back(e);
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    logic exp_vld;
    if (reset) begin
      sb.delete();
    end else begin
      while (sb.size() > 0 && sb[0].cyc < cyc) void'(sb.pop_front());
      exp_vld = (sb.size() > 0) && (sb[0].cyc == cyc);
      check("out_valid", 64'(out_valid), 64'(exp_vld));
      if (exp_vld) begin
        e = sb.pop_front();
        if (out_valid) begin
          check("out_real", 64'(out_real), 64'(e.r));
          check("out_imag", 64'(out_imag), 64'(e.i));
          check("out_first", 64'(out_first), 64'(e.f));
          check("out_last", 64'(out_last), 64'(e.l));
        end
      end
    end
  end

  task automatic drive(input int r, input int i);
    @(negedge clock);
    in_valid = 1'b1;
    in_real  = 32'(r);
    in_imag  = 32'(i);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      in_valid = 1'b0;
    end
  endtask

  // duty is the percentage chance of presenting a sample on a given cycle.
  task automatic send_frame(input int off, input int duty);
    for (int n = 0; n < 256; n++) begin
      while ($urandom_range(99) >= duty) begin
        @(negedge clock);
        in_valid = 1'b0;
      end
      drive(off + n, 255 - n);
      if (n == 255) push_frame(off, cyc + 1);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_vld"}, 64'(out_valid), 64'd0);
    check({tag, "_real"}, 64'(out_real), 64'd0);
    check({tag, "_imag"}, 64'(out_imag), 64'd0);
    check({tag, "_first"}, 64'(out_first), 64'd0);
    check({tag, "_last"}, 64'(out_last), 64'd0);
    check({tag, "_vld3"}, 64'(out_valid3), 64'd0);
  endtask

  task automatic run_small(input int rbase, input int ibase, input bit gap);
    int order [8];
    order = '{0, 4, 2, 6, 1, 5, 3, 7};
    for (int n = 0; n < 8; n++) begin
      if (gap && n == 7) begin
        @(negedge clock);
        in_valid3 = 1'b0;
      end
      @(negedge clock);
      in_valid3 = 1'b1;
      in_real3  = 16'(rbase + n);
      in_imag3  = 16'(ibase + n);
    end
    @(negedge clock);
    in_valid3 = 1'b0;
    check("s_early", 64'(out_valid3), 64'd0);
    for (int j = 0; j < 8; j++) begin
      @(negedge clock);
      check("s_vld", 64'(out_valid3), 64'd1);
      check("s_real", 64'(out_real3), 64'(rbase + order[j]));
      check("s_imag", 64'(out_imag3), 64'(ibase + order[j]));
      check("s_first", 64'(out_first3), 64'(j == 0));
      check("s_last", 64'(out_last3), 64'(j == 7));
    end
    @(negedge clock);
    check("s_end", 64'(out_valid3), 64'd0);
  endtask

  initial begin
    #2 reset = 1'b1;
    #1 check_zero("por");
    repeat (3) @(negedge clock);
    #2 reset = 1'b0;

    send_frame(0, 100);
    idle(300);

    for (int k = 0; k < 4; k++) send_frame(1000 * k, 100);
    idle(300);

    send_frame(500, 40);
    send_frame(600, 40);
    idle(300);

    run_small(0, 100, 1'b0);
    run_small(10, 200, 1'b1);

    // Abort frame 1 drain and a 100-sample partial frame 2.
    send_frame(0, 100);
    for (int n = 0; n < 100; n++) drive(5000 + n, n);
    @(posedge clock);
    #2 reset = 1'b1;
    in_valid = 1'b0;
    #1 check_zero("rst_drain");
    repeat (3) @(posedge clock);
    #1 check_zero("rst_hold");
    @(negedge clock);
    #2 reset = 1'b0;
    send_frame(7000, 100);
    idle(300);

    // Reset held while the input keeps toggling.
    @(negedge clock);
    #2 reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      in_valid = i[0];
      in_real  = 32'(8000 + i);
      in_imag  = 32'(i);
      #1 check_zero("rst_toggle");
    end
    @(negedge clock);
    in_valid = 1'b0;
    #2 reset = 1'b0;
    send_frame(9000, 100);
    idle(300);

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_output_reorder.md
# fft_output_reorder

Bit-reversal reorder buffer at the output of the radix-2 SDF 256-point FFT pipeline. The SDF stages emit each frame in bit-reversed bin order. This block writes each frame into one bank of a ping-pong memory in arrival order. It reads the other bank in bit-reversed address order, so results stream out in natural bin order (bin 0 first). It is the reader counterpart to the pipeline's write-in-order storage: the FFT writes samples in, and this block reads them back out in the order downstream expects.

## Interface
- N_LOG2, 8, log2 of frame length N (N = 2^N_LOG2 points)
- WIDTH, 32, bit width of each real and imaginary component
- clock  input  1  rising-edge clock, sole clock domain
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  one sample presented this cycle
- in_real  input  WIDTH  sample real part (SDF output, bit-reversed order)
- in_imag  input  WIDTH  sample imaginary part
- out_valid  output  1  out_real/out_imag hold a valid bin
- out_real  output  WIDTH  bin real part, natural order
- out_imag  output  WIDTH  bin imaginary part
- out_first  output  1  high with bin 0 of each frame
- out_last  output  1  high with bin N-1 of each frame

## Operation
- Storage: two banks, each N x 2·WIDTH. wr_bank selects the bank being filled; the read side drains the other bank.
- Write side:
  - On a clock edge with in_valid=1, store {in_real, in_imag} at wr_bank[wr_cnt] and increment wr_cnt (N_LOG2 bits).
  - When wr_cnt = N-1 is written, wr_cnt wraps to 0, wr_bank toggles, and frame_done pulses for one cycle.
  - in_valid=0 freezes wr_cnt. Gaps of any length are allowed.
- Read FSM, states IDLE and DRAIN:
  - IDLE -> DRAIN on frame_done: rd_bank takes the just-filled bank and rd_cnt is set to 0.
  - In DRAIN, each cycle register bank[rd_bank][bitrev(rd_cnt)] onto out_real/out_imag, set out_valid=1, then increment rd_cnt.
  - DRAIN -> IDLE after rd_cnt = N-1 is issued, unless frame_done is asserted the same cycle. In that case stay in DRAIN, swap rd_bank, and reset rd_cnt to 0 for a gapless frame-to-frame stream.
- bitrev(x) reverses the N_LOG2 bits of x. Output bin j equals input sample number bitrev(j) of the frame.
- out_first = out_valid & (issued rd_cnt == 0). out_last = out_valid & (issued rd_cnt == N-1).
- No backpressure. Input rate is at most 1 sample/cycle and a drain takes exactly N cycles, so a bank is always fully drained before it is overwritten. No overflow or underflow flags exist.
- Data is passed through unmodified; no arithmetic and no width change.
- Reset:
  - Asynchronous, active-high: wr_cnt=0, rd_cnt=0, wr_bank=0, FSM=IDLE, out_valid=0, out_first=0, out_last=0, out_real=0, out_imag=0.
  - A partial frame being written is discarded, and any drain in progress is aborted.
  - Memory contents are not cleared and are never output without a full new frame.
  - The first frame after reset is written to bank 0.

## Timing
- Let the last sample (index N-1) of a frame be captured at edge t.
  - Bin 0 is valid after edge t+1, and bin j after edge t+1+j, for j = 0..N-1. Output is 1-cycle registered.
  - Latency from last input sample to first output bin is 1 cycle. Latency from first input sample is at least N cycles, more if the input has gaps.
- Back-to-back input (in_valid held at 1):
  - out_valid stays continuously high from the first drain onward.
  - out_last of frame k and out_first of frame k+1 are on consecutive cycles.
- out_valid is never high for a frame that did not receive all N samples.
- Reset deasserted mid-cycle: the first sample written is the first in_valid edge after deassertion.

## Test plan
- Ramp, N_LOG2=8: in_real=n, in_imag=255-n for n=0..255, contiguous -> out_real sequence 0,128,64,192,32,…,255 (bitrev8(j)); out_imag = 255-bitrev8(j); out_first on j=0, out_last on j=255; first out_valid 1 cycle after sample 255.
- Four back-to-back frames with ramp offsets 0/1000/2000/3000 -> 1024 consecutive out_valid cycles with no gap; frame k output = 1000k + bitrev8(j).
- Randomly gapped input (in_valid ~40% duty) -> output identical to the contiguous case; each drain is N consecutive cycles; no frame is emitted early.
- Reset asserted after 100 samples of frame 2 while frame 1 is draining -> outputs zero and out_valid=0 immediately (asynchronously); the next full 256-sample frame is reordered correctly and no stale data appears.
- N_LOG2=3, WIDTH=16: in_real=0..7 -> out_real 0,4,2,6,1,5,3,7; then a second frame with a one-cycle gap before its last sample is correctly reordered.
- Reset held with in_valid=1 toggling -> all outputs remain 0 and nothing is written (first post-reset frame reorders correctly).
